braid_inlet_sequencer: RTL and testbench
========================================

// Module: braid_inlet_sequencer
// PURPOSE
//   Timed valve controller directly upstream of the 8x8 mixer braid. Meters fluid into the braid's
//   inputs one inlet at a time: opens the inlet valve for a programmed dwell, then opens a shared
//   flush valve to purge the common feed line before the next inlet. Inlets are visited in ascending
//   index order. A start/done handshake lets the assay scheduler run one full injection round.
// PARAMETERS
//   N_INLETS      8    number of braid inputs driven (valve_open width)
//   DWELL_W       16   width of the dwell-time operand, in clock cycles
//   FLUSH_CYCLES  4    cycles the flush valve stays open between inlets (>=1)
// PORTS
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   start        in   1         1-cycle request to begin a round; sampled only in IDLE
//   abort        in   1         level; terminate the current round safely
//   inlet_mask   in   N_INLETS  1 = inlet takes part in the round; latched at start
//   dwell        in   DWELL_W   open time per inlet in cycles; latched at start
//   valve_open   out  N_INLETS  one-hot (or zero) inlet valve drive to braid input_0..input_7
//   flush_open   out  1         shared flush/purge valve drive
//   cur_inlet    out  $clog2(N_INLETS)  index of inlet currently open or last opened
//   busy         out  1         high in every state except IDLE
//   done         out  1         1-cycle pulse: round completed normally
//   aborted      out  1         1-cycle pulse: round ended by abort
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, latched mask/dwell 0, dwell counter 0.
//   - States: IDLE, OPEN, FLUSH, FIN. All outputs registered; valve_open and flush_open never high together.
//   - IDLE: start=1 latches inlet_mask and dwell (dwell==0 becomes 1) and selects lowest set mask bit.
//     If mask==0, go to FIN (done pulses the cycle after start, no valve opened). Else go to OPEN.
//   - OPEN: valve_open[cur] high for exactly the latched dwell cycles, starting the cycle after the
//     start edge (start at edge T -> valve high from T+1 through T+dwell). Then go to FLUSH.
//   - FLUSH: flush_open high for exactly FLUSH_CYCLES cycles. Then, if a higher-index masked inlet
//     remains, go to OPEN for it; else go to FIN. Flush follows every inlet, including the last.
//   - FIN: done=1 for one cycle, busy=0 in the following cycle, return to IDLE.
//   - start while busy is ignored (no re-latch, no queueing). Input mask/dwell changes mid-round
//     have no effect.
//   - abort=1 in OPEN: close inlet valve next cycle, enter FLUSH for the full FLUSH_CYCLES, then
//     pulse aborted (not done) and return to IDLE. abort=1 in FLUSH: finish the flush, then aborted.
//     abort in IDLE/FIN: no effect; FIN still pulses done. abort and start same cycle in IDLE: start wins.
//   - Dwell counter is DWELL_W bits, counts down from latched dwell; no wrap/overflow possible;
//     dwell = 2^DWELL_W-1 is legal.
//   - rst_n asserted mid-round: all valves close immediately (asynchronous), no done/aborted pulse.
//   - cur_inlet holds its value in IDLE after a round; reset to 0.
// STRUCTURE
//   - Package braid_seq_pkg: state enum (IDLE/OPEN/FLUSH/FIN), default N_INLETS, DWELL_W,
//     FLUSH_CYCLES constants.
//   - Sub-module braid_next_inlet: combinational priority pick of the lowest set mask bit strictly
//     above a given index (plus "found" flag); used for first pick (index -1) and advance.
//   - Top holds FSM, dwell counter, flush counter and output registers.
// TESTING
//   - Reset: hold rst_n=0 with start=1 -> all outputs 0; release -> stays IDLE, busy=0.
//   - mask=8'b1000_0101, dwell=3, FLUSH_CYCLES=4, start @T -> valve_open=0x01 T+1..T+3, flush
//     T+4..T+7, 0x04 T+8..T+10, flush T+11..T+14, 0x80 T+15..T+17, flush T+18..T+21, done @T+22.
//   - mask=0, start @T -> done @T+1, valve_open/flush_open never high, busy only at T+1.
//   - dwell=0, mask=0x02 -> valve_open=0x02 exactly 1 cycle, then 4 flush cycles, done.
//   - mask=0xFF, dwell=10, abort pulse on 5th open cycle of inlet 2 -> valve closes next cycle,
//     4 flush cycles, aborted pulse, no done, inlets 3..7 never opened; start during round ignored.
//   - rst_n low mid-OPEN -> valve_open=0 asynchronously; after release new start runs a clean round.

Source files
------------

// File: rtl/braid_seq_pkg.sv
// Shared types and default sizing for the braid inlet sequencer.
package braid_seq_pkg;

  localparam int unsigned DEF_N_INLETS     = 8;
  localparam int unsigned DEF_DWELL_W      = 16;
  localparam int unsigned DEF_FLUSH_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPEN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/braid_next_inlet.sv
// Combinational pick of the lowest set mask bit strictly above 'after'.
// With from_none set, the search starts below bit 0 and bit 0 itself is eligible.
module braid_next_inlet #(
  parameter int unsigned N_INLETS = 8,
  localparam int unsigned IDX_W   = $clog2(N_INLETS)
) (
  input  logic [N_INLETS-1:0] mask,
  input  logic [IDX_W-1:0]    after,
  input  logic                from_none,
  output logic [IDX_W-1:0]    next_idx_c,
  output logic                found_c
);

  // Descending scan so the lowest eligible bit is the last one written.
  always_comb begin
    next_idx_c = '0;
    found_c    = 1'b0;
    for (int i = int'(N_INLETS) - 1; i >= 0; i--) begin
      if (mask[i] && (from_none || (i > int'(after)))) begin
        next_idx_c = IDX_W'(i);
        found_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/braid_inlet_sequencer.sv
// Timed inlet valve sequencer feeding the mixer braid: opens each selected inlet for
// the latched dwell, purges the shared feed line after each one, then reports done/aborted.
module braid_inlet_sequencer
  import braid_seq_pkg::*;
#(
  parameter int unsigned N_INLETS     = DEF_N_INLETS,
  parameter int unsigned DWELL_W      = DEF_DWELL_W,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_INLETS-1:0]         inlet_mask,
  input  logic [DWELL_W-1:0]          dwell,
  output logic [N_INLETS-1:0]         valve_open,
  output logic                        flush_open,
  output logic [$clog2(N_INLETS)-1:0] cur_inlet,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
);

  localparam int unsigned IDX_W   = $clog2(N_INLETS);
  localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 1);

  seq_state_e           state_q, state_d;
  logic [N_INLETS-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [FLUSH_W-1:0]   fcnt_q, fcnt_d;
  logic                 abort_pend_q, abort_pend_d;
  logic [N_INLETS-1:0]  valve_d;
  logic                 flush_d, busy_d, done_d, aborted_d;
  logic [IDX_W-1:0]     cur_d;

  logic [DWELL_W-1:0]   dwell_eff_c;
  logic [IDX_W-1:0]     first_idx_c, next_idx_c;
  logic                 first_found_c, next_found_c;

  // A zero dwell still opens the valve for one cycle.
  assign dwell_eff_c = (dwell == '0) ? DWELL_W'(1) : dwell;

  braid_next_inlet #(.N_INLETS(N_INLETS)) u_first_pick (
    .mask       (inlet_mask),
    .after      ('0),
    .from_none  (1'b1),
    .next_idx_c (first_idx_c),
    .found_c    (first_found_c)
  );

  braid_next_inlet #(.N_INLETS(N_INLETS)) u_advance_pick (
    .mask       (mask_q),
    .after      (cur_inlet),
    .from_none  (1'b0),
    .next_idx_c (next_idx_c),
    .found_c    (next_found_c)
  );

  // Next-state and next-output logic; every output is the registered copy of its _d value.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    dwell_d      = dwell_q;
    cnt_d        = cnt_q;
    fcnt_d       = fcnt_q;
    abort_pend_d = abort_pend_q;
    valve_d      = valve_open;
    flush_d      = flush_open;
    cur_d        = cur_inlet;
    busy_d       = busy;
    done_d       = 1'b0;
    aborted_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mask_d       = inlet_mask;
          dwell_d      = dwell_eff_c;
          abort_pend_d = 1'b0;
          busy_d       = 1'b1;
          if (first_found_c) begin
            state_d = ST_OPEN;
            cur_d   = first_idx_c;
            valve_d = N_INLETS'(1) << first_idx_c;
            cnt_d   = dwell_eff_c;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end
      end

      ST_OPEN: begin
        if (abort || (cnt_q == DWELL_W'(1))) begin
          state_d      = ST_FLUSH;
          valve_d      = '0;
          flush_d      = 1'b1;
          fcnt_d       = FLUSH_W'(FLUSH_CYCLES);
          abort_pend_d = abort_pend_q | abort;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end

      ST_FLUSH: begin
        abort_pend_d = abort_pend_q | abort;
        if (fcnt_q == FLUSH_W'(1)) begin
          flush_d = 1'b0;
          if (abort_pend_q || abort) begin
            state_d   = ST_FIN;
            aborted_d = 1'b1;
          end else if (next_found_c) begin
            state_d = ST_OPEN;
            cur_d   = next_idx_c;
            valve_d = N_INLETS'(1) << next_idx_c;
            cnt_d   = dwell_q;
          end else begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end
        end else begin
          fcnt_d = fcnt_q - FLUSH_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        valve_d = '0;
        flush_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      dwell_q      <= '0;
      cnt_q        <= '0;
      fcnt_q       <= '0;
      abort_pend_q <= 1'b0;
      valve_open   <= '0;
      flush_open   <= 1'b0;
      cur_inlet    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      dwell_q      <= dwell_d;
      cnt_q        <= cnt_d;
      fcnt_q       <= fcnt_d;
      abort_pend_q <= abort_pend_d;
      valve_open   <= valve_d;
      flush_open   <= flush_d;
      cur_inlet    <= cur_d;
      busy         <= busy_d;
      done         <= done_d;
      aborted      <= aborted_d;
    end
  end

endmodule

// File: tb/tb_braid_inlet_sequencer.sv
// Self-checking bench for braid_inlet_sequencer: table of rounds expanded into a
// per-cycle expected trace (scoreboard queue), plus hand-written reset sequences.
module tb_braid_inlet_sequencer;

  localparam int unsigned N  = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned FC = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [N-1:0]  inlet_mask;
  logic [DW-1:0] dwell;
  logic [N-1:0]  valve_open;
  logic          flush_open;
  logic [2:0]    cur_inlet;
  logic          busy;
  logic          done;
  logic          aborted;

  always #5 clk = ~clk;

  braid_inlet_sequencer #(
    .N_INLETS     (N),
    .DWELL_W      (DW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .inlet_mask (inlet_mask),
    .dwell      (dwell),
    .valve_open (valve_open),
    .flush_open (flush_open),
    .cur_inlet  (cur_inlet),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  // One expected output cycle, plus the inputs to drive during that cycle.
  typedef struct {
    logic [7:0] valve;
    logic       flush;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] cur;
    logic       drv_abort;
    logic       drv_start;
  } cyc_t;

  // One round: stimulus plus hand-derived busy length and ending.
  typedef struct {
    logic [7:0]  mask;
    logic [15:0] dwell;
    int          ab_inlet;   // -1: no abort during the inlet slots
    int          ab_k;       // abort on the k-th cycle (1-based) of that inlet's open+flush slot
    bit          ab_start;   // abort raised together with start
    bit          ab_fin;     // abort raised in the done cycle
    bit          mid_start;  // extra start pulse while busy
    int          exp_busy;
    bit          exp_aborted;
  } vec_t;

  cyc_t       q[$];
  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_cur = 3'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expand a round into the cycle-by-cycle trace the sequencer must produce.
  task automatic build(input vec_t v);
    cyc_t e;
    int   eff;
    int   open_n;
    bit   ab;
    eff = (v.dwell == 16'd0) ? 1 : int'(v.dwell);
    ab  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (v.mask[i]) begin
        exp_cur = 3'(i);
        open_n  = eff;
        if (v.ab_inlet == i) begin
          ab = 1'b1;
          if (v.ab_k <= eff) open_n = v.ab_k;
        end
        for (int k = 0; k < open_n; k++) begin
          e = '{default: '0};
          e.valve = 8'(1) << i;
          e.busy = 1'b1;
          e.cur = exp_cur;
          e.drv_abort = (v.ab_inlet == i) && (k + 1 == v.ab_k);
          q.push_back(e);
        end
        for (int k = 0; k < int'(FC); k++) begin
          e = '{default: '0};
          e.flush = 1'b1;
          e.busy = 1'b1;
          e.cur = exp_cur;
          e.drv_abort = ab && (v.ab_k > eff) && (open_n + k + 1 == v.ab_k);
          q.push_back(e);
        end
        if (ab) break;
      end
    end
    e = '{default: '0};
    e.busy = 1'b1;
    e.done = !ab;
    e.aborted = ab;
    e.cur = exp_cur;
    e.drv_abort = v.ab_fin;
    q.push_back(e);
    e = '{default: '0};
    e.cur = exp_cur;
    q.push_back(e);
    if (v.mid_start && q.size() > 4) q[2].drv_start = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    cyc_t e;
    int   cyc, busy_n, done_n, ab_n;
    build(v);
    @(negedge clk);
    start = 1'b1;
    inlet_mask = v.mask;
    dwell = v.dwell;
    abort = v.ab_start;
    cyc = 0; busy_n = 0; done_n = 0; ab_n = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      cyc++;
      check($sformatf("v%0d valve c%0d", idx, cyc), 32'(valve_open), 32'(e.valve));
      check($sformatf("v%0d flush c%0d", idx, cyc), 32'(flush_open), 32'(e.flush));
      check($sformatf("v%0d busy c%0d", idx, cyc), 32'(busy), 32'(e.busy));
      check($sformatf("v%0d done c%0d", idx, cyc), 32'(done), 32'(e.done));
      check($sformatf("v%0d aborted c%0d", idx, cyc), 32'(aborted), 32'(e.aborted));
      check($sformatf("v%0d cur c%0d", idx, cyc), 32'(cur_inlet), 32'(e.cur));
      check($sformatf("v%0d excl c%0d", idx, cyc), 32'((valve_open != 8'd0) && flush_open), 32'(0));
      busy_n += int'(busy);
      done_n += int'(done);
      ab_n   += int'(aborted);
      start = e.drv_start;
      abort = e.drv_abort;
      if (e.drv_start) begin
        inlet_mask = 8'hFF;
        dwell = 16'd1;
      end else begin
        inlet_mask = 8'($urandom);
        dwell = 16'($urandom);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    check($sformatf("v%0d busy_len", idx), 32'(busy_n), 32'(v.exp_busy));
    check($sformatf("v%0d done_cnt", idx), 32'(done_n), 32'(!v.exp_aborted));
    check($sformatf("v%0d aborted_cnt", idx), 32'(ab_n), 32'(v.exp_aborted));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    //          mask    dwell    inl  k  abS  abF  mid  busy ab
    vecs[0] = '{8'h85, 16'd3,   -1,  0, 1'b0, 1'b0, 1'b0, 22, 1'b0};
    vecs[1] = '{8'h00, 16'd7,   -1,  0, 1'b0, 1'b0, 1'b0, 1,  1'b0};
    vecs[2] = '{8'h02, 16'd0,   -1,  0, 1'b0, 1'b0, 1'b0, 6,  1'b0};
    vecs[3] = '{8'hFF, 16'd10,   2,  5, 1'b0, 1'b0, 1'b1, 38, 1'b1};
    vecs[4] = '{8'h01, 16'd1,   -1,  0, 1'b1, 1'b0, 1'b0, 6,  1'b0};
    vecs[5] = '{8'h60, 16'd2,    6,  4, 1'b0, 1'b0, 1'b0, 13, 1'b1};
    vecs[6] = '{8'h80, 16'd257, -1,  0, 1'b0, 1'b0, 1'b0, 262, 1'b0};
    vecs[7] = '{8'h18, 16'd1,   -1,  0, 1'b0, 1'b1, 1'b0, 11, 1'b0};
    vecs[8] = '{8'h01, 16'd5,    0,  5, 1'b0, 1'b0, 1'b0, 10, 1'b1};

    // Reset held with start asserted: everything stays zero.
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    inlet_mask = 8'hFF;
    dwell = 16'd5;
    repeat (3) @(negedge clk);
    check("rst valve", 32'(valve_open), 32'(0));
    check("rst flush", 32'(flush_open), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst aborted", 32'(aborted), 32'(0));
    check("rst cur", 32'(cur_inlet), 32'(0));
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst busy", 32'(busy), 32'(0));
    check("post_rst valve", 32'(valve_open), 32'(0));

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Asynchronous reset in the middle of an open dwell.
    @(negedge clk);
    start = 1'b1;
    inlet_mask = 8'h10;
    dwell = 16'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst pre valve", 32'(valve_open), 32'(8'h10));
    check("midrst pre cur", 32'(cur_inlet), 32'(4));
    #2 rst_n = 1'b0;
    #1;
    check("midrst async valve", 32'(valve_open), 32'(0));
    check("midrst async busy", 32'(busy), 32'(0));
    check("midrst async cur", 32'(cur_inlet), 32'(0));
    @(negedge clk);
    check("midrst held flush", 32'(flush_open), 32'(0));
    check("midrst held done", 32'(done), 32'(0));
    check("midrst held aborted", 32'(aborted), 32'(0));
    rst_n = 1'b1;
    exp_cur = 3'd0;
    run_vec(9, vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
